instr_encoder: RTL

- Sequential instruction encoder and loader: the encoding counterpart of the control decoder. It accepts symbolic instruction commands (kind, register fields, immediate, target), encodes them into 32-bit MIPS words, and writes them to consecutive instruction-memory word addresses through a write/ack handshake.
- Sits between a testbench/boot sequencer and instruction memory. Programs the memory before the CPU is released from reset.
- Branch offsets are computed PC-relative from the current write address.

---
 rtl/instr_enc_pkg.sv | 62 ++++++
 rtl/instr_field_encode.sv | 67 ++++++
 rtl/instr_encoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/instr_enc_pkg.sv
// Shared encodings for the instruction encoder: command kinds, MIPS opcode and
// funct fields, error codes, FSM states and word-packing helpers.
package instr_enc_pkg;

  typedef enum logic [3:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_OR   = 4'd3,
    KIND_SLT  = 4'd4,
    KIND_JR   = 4'd5,
    KIND_BEQ  = 4'd6,
    KIND_ADDI = 4'd7,
    KIND_SLTI = 4'd8,
    KIND_LW   = 4'd9,
    KIND_SW   = 4'd10,
    KIND_J    = 4'd11,
    KIND_JAL  = 4'd12
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_JR  = 6'h08;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_RANGE   = 2'd2,
    ERR_FULL    = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_field_encode.sv
// Combinational MIPS field packer: turns one symbolic command into a 32-bit word
// and flags illegal kinds or jump/branch targets outside the writable range.
module instr_field_encode
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic [3:0]        kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       word,
  output logic              illegal,
  output logic              range_err
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [ADDR_W:0] beq_diff;
  logic [15:0]     beq_imm;
  logic [25:0]     jump_field;
  logic            uses_target;

  // Branch offset is relative to the word after the branch, kept one bit wider
  // than the address so backward offsets carry their sign into the immediate.
  assign beq_diff   = {1'b0, target} - {1'b0, addr} - 1'b1;
  assign beq_imm    = 16'(signed'(beq_diff));
  assign jump_field = 26'(target);

  always_comb begin
    word        = '0;
    illegal     = 1'b0;
    uses_target = 1'b0;
    case (kind)
      KIND_ADD:  word = r_word(rs, rt, rd, FN_ADD);
      KIND_SUB:  word = r_word(rs, rt, rd, FN_SUB);
      KIND_AND:  word = r_word(rs, rt, rd, FN_AND);
      KIND_OR:   word = r_word(rs, rt, rd, FN_OR);
      KIND_SLT:  word = r_word(rs, rt, rd, FN_SLT);
      KIND_JR:   word = r_word(rs, 5'd0, 5'd0, FN_JR);
      KIND_BEQ: begin
        word        = i_word(OP_BEQ, rs, rt, beq_imm);
        uses_target = 1'b1;
      end
      KIND_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
      KIND_SLTI: word = i_word(OP_SLTI, rs, rt, imm);
      KIND_LW:   word = i_word(OP_LW, rs, rt, imm);
      KIND_SW:   word = i_word(OP_SW, rs, rt, imm);
      KIND_J: begin
        word        = {OP_J, jump_field};
        uses_target = 1'b1;
      end
      KIND_JAL: begin
        word        = {OP_JAL, jump_field};
        uses_target = 1'b1;
      end
      default:   illegal = 1'b1;
    endcase
  end

  assign range_err = uses_target && (32'(target) >= DEPTH_W);

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction loader: accepts symbolic commands, encodes them and
// writes them to consecutive instruction-memory words through a write/ack handshake.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [3:0]        cmd_kind_i,
  input  logic [4:0]        cmd_rs_i,
  input  logic [4:0]        cmd_rt_i,
  input  logic [4:0]        cmd_rd_i,
  input  logic [15:0]       cmd_imm_i,
  input  logic [ADDR_W-1:0] cmd_target_i,
  input  logic              cmd_last_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  input  logic              imem_ack_i,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       DEPTH_W = 32'(DEPTH);

  state_e          state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_inc;
  logic [31:0]       word_q;
  logic              last_q;
  err_e              err_code_q;
  err_e              err_next;

  logic [31:0] word_enc;
  logic        illegal;
  logic        range_err;
  logic        capture;
  logic        advance;
  logic        restart;
  logic        err_set;
  logic        full;

  instr_field_encode #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_field_encode (
    .kind      (cmd_kind_i),
    .rs        (cmd_rs_i),
    .rt        (cmd_rt_i),
    .rd        (cmd_rd_i),
    .imm       (cmd_imm_i),
    .target    (cmd_target_i),
    .addr      (addr),
    .word      (word_enc),
    .illegal   (illegal),
    .range_err (range_err)
  );

  assign count_inc = count + 1'b1;
  assign full      = (32'(count_inc) == DEPTH_W);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    advance     = 1'b0;
    restart     = 1'b0;
    err_set     = 1'b0;
    err_next    = ERR_NONE;
    cmd_ready_o = 1'b0;
    imem_we_o   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_next = ST_ACCEPT;
          restart    = 1'b1;
        end
      end
      ST_ACCEPT: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          capture = 1'b1;
          if (illegal) begin
            state_next = ST_ERR;
            err_set    = 1'b1;
            err_next   = ERR_ILLEGAL;
          end else if (range_err) begin
            state_next = ST_ERR;
            err_set    = 1'b1;
            err_next   = ERR_RANGE;
          end else begin
            state_next = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        imem_we_o = 1'b1;
        if (imem_ack_i) begin
          advance = 1'b1;
          if (last_q) begin
            state_next = ST_DONE;
          end else if (full) begin
            state_next = ST_ERR;
            err_set    = 1'b1;
            err_next   = ERR_FULL;
          end else begin
            state_next = ST_ACCEPT;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Word and last flag are captured at the command handshake so address and data
  // stay stable for however long the memory withholds its ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr       <= BASE;
      count      <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      if (restart) begin
        addr       <= BASE;
        count      <= '0;
        err_code_q <= ERR_NONE;
      end
      if (capture) begin
        word_q <= word_enc;
        last_q <= cmd_last_i;
      end
      if (advance) begin
        addr  <= addr + 1'b1;
        count <= count_inc;
      end
      if (err_set) err_code_q <= err_next;
    end
  end

  assign imem_addr_o  = addr;
  assign imem_wdata_o = word_q;
  assign done_o       = (state == ST_DONE);
  assign err_o        = (state == ST_ERR);
  assign err_code_o   = err_code_q;
  assign count_o      = count;

endmodule
